// File: rtl/gray_sweep_pkg.sv
// Shared types and defaults for the Gray-sweep arbiter and its datapath.
package gray_sweep_pkg;

  localparam int unsigned DefWidth  = 3;
  localparam int unsigned DefStepsW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/gray_step.sv
// Gray-code datapath register: moves one code up or down when en_i is high.
module gray_step #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             up_i,
  output logic [Width-1:0] value_o
);

  logic [Width-1:0] value_q, value_d;
  logic [Width-1:0] bin, bin_nxt;

  // Step in binary space and re-encode; keeps the code sequence exact for any width.
  always_comb begin
    for (int i = 0; i < int'(Width); i++) begin
      bin[i] = ^(value_q >> i);
    end
    bin_nxt = up_i ? (bin + Width'(1)) : (bin - Width'(1));
    value_d = en_i ? (bin_nxt ^ (bin_nxt >> 1)) : value_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/gray_sweep_arbiter.sv
// Round-robin owner of a shared Gray counter; each grant runs a sweep of N steps.
// Optional early termination on dropped request: define GRAY_SWEEP_ABORT_EN.
module gray_sweep_arbiter
  import gray_sweep_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned STEPS_W = DefStepsW
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         req_i,
  input  logic [1:0]         up_not_down_i,
  input  logic [STEPS_W-1:0] steps0_i,
  input  logic [STEPS_W-1:0] steps1_i,
  output logic [1:0]         grant_o,
  output logic               busy_o,
  output logic [1:0]         done_o,
  output logic [WIDTH-1:0]   gray_o
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               dir_q, dir_d;
  logic               last_q, last_d;
  logic [STEPS_W-1:0] rem_q, rem_d;
  logic               winner;
  logic               step_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      last_q  <= 1'b1;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    last_d  = last_q;
    rem_d   = rem_q;
    step_en = 1'b0;
    // On contention the requester not served last wins.
    winner  = (req_i == 2'b11) ? ~last_q : req_i[1];
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          owner_d = winner;
          last_d  = winner;
          dir_d   = up_not_down_i[winner];
          rem_d   = winner ? steps1_i : steps0_i;
          state_d = StRun;
        end
      end
      StRun: begin
`ifdef GRAY_SWEEP_ABORT_EN
        if (!req_i[owner_q]) begin
          state_d = StDone;
        end else if (rem_q != '0) begin
          step_en = 1'b1;
          rem_d   = rem_q - STEPS_W'(1);
        end else begin
          state_d = StDone;
        end
`else
        if (rem_q != '0) begin
          step_en = 1'b1;
          rem_d   = rem_q - STEPS_W'(1);
        end else begin
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    grant_o = 2'b00;
    done_o  = 2'b00;
    if (state_q != StIdle) begin
      grant_o = owner_q ? 2'b10 : 2'b01;
    end
    if (state_q == StDone) begin
      done_o = grant_o;
    end
    busy_o = |grant_o;
  end

  gray_step #(
    .Width(WIDTH)
  ) u_gray_step (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (step_en),
    .up_i   (dir_q),
    .value_o(gray_o)
  );

endmodule

// File: tb/tb_gray_sweep_arbiter.sv
// Scoreboard bench for gray_sweep_arbiter: model predicts sweeps, monitor checks outputs.
module tb_gray_sweep_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_i = 2'b00;
  logic [1:0] up_i = 2'b00;
  logic [2:0] steps0 = 3'd0;
  logic [2:0] steps1 = 3'd0;
  logic [1:0] grant_o;
  logic       busy_o;
  logic [1:0] done_o;
  logic [2:0] gray_o;

  always #5 clk = ~clk;

  gray_sweep_arbiter #(
    .WIDTH  (3),
    .STEPS_W(3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req_i),
    .up_not_down_i(up_i),
    .steps0_i     (steps0),
    .steps1_i     (steps1),
    .grant_o      (grant_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .gray_o       (gray_o)
  );

  typedef struct {
    logic [1:0] done;
    logic [2:0] gray;
    int         len;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] gray_q[$];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         m_pos = 0;
  int         m_last = 1;
  logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  // Round-robin rule: contention goes to whoever was not served last.
  function automatic int pick(logic [1:0] r);
    int w;
    w = (r == 2'b11) ? (1 - m_last) : ((r == 2'b10) ? 1 : 0);
    m_last = w;
    return w;
  endfunction

  function automatic void model_sweep(int owner, logic up, int taken);
    exp_t e;
    for (int i = 0; i < taken; i++) begin
      m_pos = up ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
      gray_q.push_back(seq[m_pos]);
    end
    e.done = (owner == 1) ? 2'b10 : 2'b01;
    e.gray = seq[m_pos];
    e.len  = taken + 2;
    exp_q.push_back(e);
  endfunction

  initial begin
    logic [2:0] prev;
    int         glen;
    exp_t       e;
    prev = 3'd0;
    glen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = gray_o;
        glen = 0;
      end else begin
        check("busy_vs_grant", int'(busy_o), int'(|grant_o));
        if (gray_o !== prev) begin
          if (gray_q.size() == 0) check("unexpected_gray_step", int'(gray_o), int'(prev));
          else check("gray_step", int'(gray_o), int'(gray_q.pop_front()));
          prev = gray_o;
        end
        glen = (grant_o != 2'b00) ? glen + 1 : 0;
        if (done_o != 2'b00) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", int'(done_o), 0);
          end else begin
            e = exp_q.pop_front();
            check("done_owner", int'(done_o), int'(e.done));
            check("done_gray", int'(gray_o), int'(e.gray));
            check("grant_cycles", glen, e.len);
            check("grant_at_done", int'(grant_o), int'(e.done));
          end
        end
      end
    end
  end

  task automatic wait_grant(int budget);
    int n = 0;
    while (grant_o == 2'b00 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("grant_seen", int'(grant_o != 2'b00), 1);
  endtask

  task automatic wait_done(int target, int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_seen", int'(done_cnt >= target), 1);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_gray"}, int'(gray_o), 0);
    check({tag, "_grant"}, int'(grant_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = 2'b00;
    exp_q.delete();
    gray_q.delete();
    m_pos = 0;
    m_last = 1;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Holds req for 'count' grants; with count==1 may drop req and scramble inputs mid-sweep.
  task automatic run_group(logic [1:0] r, logic [1:0] up, logic [2:0] s0, logic [2:0] s1,
                           int count, bit drop_early);
    int w;
    int target;
    @(posedge clk);
    #1;
    req_i = r;
    up_i = up;
    steps0 = s0;
    steps1 = s1;
    for (int i = 0; i < count; i++) begin
      w = pick(r);
      model_sweep(w, up[w], (w == 1) ? int'(s1) : int'(s0));
    end
    target = done_cnt + count;
`ifdef GRAY_SWEEP_ABORT_EN
    drop_early = 1'b0;
`endif
    if (count == 1 && drop_early) begin
      wait_grant(4);
      req_i = 2'b00;
      up_i = ~up;
      steps0 = ~s0;
      steps1 = ~s1;
    end
    wait_done(target, 12 * count + 4);
    req_i = 2'b00;
  endtask

  initial begin
    int w;
    int target;
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    run_group(2'b01, 2'b01, 3'd3, 3'd0, 1, 1'b1);
    do_reset();
    run_group(2'b10, 2'b00, 3'd0, 3'd2, 1, 1'b0);
    do_reset();
    run_group(2'b11, 2'b11, 3'd2, 3'd3, 3, 1'b0);
    run_group(2'b01, 2'b10, 3'd0, 3'd5, 1, 1'b0);

    // Reset in the middle of a 5-step sweep, req still held afterwards.
    @(posedge clk);
    #1;
    req_i = 2'b01;
    up_i = 2'b01;
    steps0 = 3'd5;
    model_sweep(pick(2'b01), 1'b1, 5);
    wait_grant(4);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    gray_q.delete();
    m_pos = 0;
    m_last = 1;
    #1;
    check_reset_outputs("midrun");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_sweep(pick(2'b01), 1'b1, 5);
    wait_done(done_cnt + 1, 16);
    req_i = 2'b00;

    // Request dropped after two steps of a 7-step sweep.
    do_reset();
    @(posedge clk);
    #1;
    req_i = 2'b01;
    up_i = 2'b01;
    steps0 = 3'd7;
    w = pick(2'b01);
`ifdef GRAY_SWEEP_ABORT_EN
    model_sweep(w, 1'b1, 2);
`else
    model_sweep(w, 1'b1, 7);
`endif
    target = done_cnt + 1;
    wait_grant(4);
    repeat (2) @(posedge clk);
    #1;
    req_i = 2'b00;
    wait_done(target, 16);

    for (int i = 0; i < 30; i++) begin
      run_group(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("exp_queue_drained", exp_q.size(), 0);
    check("gray_queue_drained", gray_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
